// File: rtl/voice_allocator_if.sv
// Event and voice-bank signals between the note decoder (master) and the voice allocator (slave).
`timescale 1ns/1ps
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4,
    parameter int DIV_WIDTH  = 19
);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    logic                            event_valid;
    logic                            event_ready;
    logic                            event_is_on;
    logic [DIV_WIDTH-1:0]            event_divider;
    logic                            all_off;
    logic [NUM_VOICES-1:0]           voice_enable;
    logic [NUM_VOICES*DIV_WIDTH-1:0] voice_divider;
    logic [CNT_W-1:0]                active_count;
    logic                            event_dropped;

    modport master (
        output event_valid,
        output event_is_on,
        output event_divider,
        output all_off,
        input  event_ready,
        input  voice_enable,
        input  voice_divider,
        input  active_count,
        input  event_dropped
    );

    modport slave (
        input  event_valid,
        input  event_is_on,
        input  event_divider,
        input  all_off,
        output event_ready,
        output voice_enable,
        output voice_divider,
        output active_count,
        output event_dropped
    );
endinterface

// File: rtl/voice_allocator.sv
// Polyphony controller: maps note_on/note_off events onto a bank of square-wave voices.
// Define VOICE_STEAL_EN to steal a busy voice instead of dropping a note_on when every voice is in use.
`timescale 1ns/1ps
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int DIV_WIDTH  = 19
) (
    input logic              clk,
    input logic              rst,
    voice_allocator_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(NUM_VOICES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_RESTORE = 2'd3
    } state_t;

    state_t                          state_q;
    logic                            ready_q;
    logic                            ev_is_on_q;
    logic [DIV_WIDTH-1:0]            ev_div_q;
    logic                            match_found_q;
    logic                            free_found_q;
    logic [IDX_W-1:0]                match_idx_q;
    logic [IDX_W-1:0]                free_idx_q;
    logic [NUM_VOICES-1:0]           voice_enable_q;
    logic [NUM_VOICES-1:0]           voice_enable_d;
    logic [DIV_WIDTH-1:0]            voice_div_q [NUM_VOICES];
    logic [DIV_WIDTH-1:0]            voice_div_d [NUM_VOICES];
    logic [CNT_W-1:0]                active_q;
    logic                            dropped_q;

    logic                            match_found_s;
    logic                            free_found_s;
    logic [IDX_W-1:0]                match_idx_s;
    logic [IDX_W-1:0]                free_idx_s;
    logic                            drop_s;
    logic [NUM_VOICES*DIV_WIDTH-1:0] voice_div_flat_s;
`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0]                steal_ptr_q;
    logic [IDX_W-1:0]                victim_q;
    logic                            steal_s;
`endif

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_VOICES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Priority search: descending scan so the lowest-index hit is the one kept
    always_comb begin
        match_found_s = 1'b0;
        match_idx_s   = '0;
        free_found_s  = 1'b0;
        free_idx_s    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            match_idx_s   = (voice_enable_q[i] && (voice_div_q[i] == ev_div_q)) ? IDX_W'(i) : match_idx_s;
            match_found_s = match_found_s | (voice_enable_q[i] && (voice_div_q[i] == ev_div_q));
            free_idx_s    = (!voice_enable_q[i]) ? IDX_W'(i) : free_idx_s;
            free_found_s  = free_found_s | !voice_enable_q[i];
        end
    end

    // Next state of the voice bank; all_off wins over any commit or restore
    always_comb begin
        voice_enable_d = voice_enable_q;
        voice_div_d    = voice_div_q;
        drop_s         = 1'b0;
`ifdef VOICE_STEAL_EN
        steal_s        = 1'b0;
`endif
        if (bus.all_off) begin
            voice_enable_d = '0;
        end else if (state_q == ST_COMMIT) begin
            if (ev_is_on_q) begin
                if ((ev_div_q == '0) || match_found_q) begin
                    voice_enable_d = voice_enable_q;
                end else if (free_found_q) begin
                    voice_enable_d[free_idx_q] = 1'b1;
                    voice_div_d[free_idx_q]    = ev_div_q;
                end else begin
`ifdef VOICE_STEAL_EN
                    // Enable drops for one cycle so the oscillator restarts its phase
                    voice_enable_d[steal_ptr_q] = 1'b0;
                    voice_div_d[steal_ptr_q]    = ev_div_q;
                    steal_s                     = 1'b1;
`else
                    drop_s = 1'b1;
`endif
                end
            end else begin
                if (match_found_q) begin
                    voice_enable_d[match_idx_q] = 1'b0;
                end else begin
                    voice_enable_d = voice_enable_q;
                end
            end
`ifdef VOICE_STEAL_EN
        end else if (state_q == ST_RESTORE) begin
            voice_enable_d[victim_q] = 1'b1;
`endif
        end else begin
            voice_enable_d = voice_enable_q;
        end
    end

    // Flatten per-voice dividers onto the output bus
    always_comb begin
        voice_div_flat_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_div_flat_s[i*DIV_WIDTH +: DIV_WIDTH] = voice_div_q[i];
        end
    end

    // Control FSM and all registered state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ready_q        <= 1'b1;
            ev_is_on_q     <= 1'b0;
            ev_div_q       <= '0;
            match_found_q  <= 1'b0;
            free_found_q   <= 1'b0;
            match_idx_q    <= '0;
            free_idx_q     <= '0;
            voice_enable_q <= '0;
            voice_div_q    <= '{default: '0};
            active_q       <= '0;
            dropped_q      <= 1'b0;
`ifdef VOICE_STEAL_EN
            steal_ptr_q    <= '0;
            victim_q       <= '0;
`endif
        end else begin
            voice_enable_q <= voice_enable_d;
            voice_div_q    <= voice_div_d;
            active_q       <= popcount(voice_enable_d);
            dropped_q      <= drop_s;
            if (bus.all_off) begin
                state_q <= ST_IDLE;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.event_valid && ready_q) begin
                            ev_is_on_q <= bus.event_is_on;
                            ev_div_q   <= bus.event_divider;
                            state_q    <= ST_LOOKUP;
                            ready_q    <= 1'b0;
                        end else begin
                            state_q    <= ST_IDLE;
                            ready_q    <= 1'b1;
                        end
                    end
                    ST_LOOKUP: begin
                        match_found_q <= match_found_s;
                        match_idx_q   <= match_idx_s;
                        free_found_q  <= free_found_s;
                        free_idx_q    <= free_idx_s;
                        state_q       <= ST_COMMIT;
                    end
                    ST_COMMIT: begin
`ifdef VOICE_STEAL_EN
                        if (steal_s) begin
                            victim_q    <= steal_ptr_q;
                            steal_ptr_q <= (steal_ptr_q == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + IDX_W'(1);
                            state_q     <= ST_RESTORE;
                        end else begin
                            state_q     <= ST_IDLE;
                            ready_q     <= 1'b1;
                        end
`else
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
`endif
                    end
`ifdef VOICE_STEAL_EN
                    ST_RESTORE: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
`endif
                    default: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.event_ready   = ready_q;
    assign bus.voice_enable  = voice_enable_q;
    assign bus.voice_divider = voice_div_flat_s;
    assign bus.active_count  = active_q;
    assign bus.event_dropped = dropped_q;

endmodule
